cpu_irq_controller: RTL

//   Platform-level external interrupt arbiter feeding the CSR file's mei_pending input.

---
 rtl/cpu_irq_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_irq_controller.sv
// cpu_irq_controller
//   External interrupt arbiter for the M-mode core. It latches NUM_SRC external
//   sources as pending and picks the highest-priority enabled source above the
//   threshold. mei_pending drives mip.MEIP. A claim/complete handshake over a
//   small MMIO port lets the trap handler service one source at a time.
//
//   Optional feature: define IRQ_EDGE_EN to add the EDGE register (0x10), which
//   makes individual sources rising-edge triggered. Without it, every source
//   is level-triggered, 0x10 reads as zero and writes to it are ignored.
//
//   Register map (word byte addresses, addr[1:0] ignored):
//     0x00 PENDING   RO   bit i = ID i pending
//     0x04 ENABLE    RW   bit i enables ID i (bit 0 reads 0)
//     0x08 THRESHOLD RW   [PRIO_W-1:0]
//     0x0C CLAIM     R: claim winner ID, W: complete ID in wdata[4:0]
//     0x10 EDGE      RW   only with IRQ_EDGE_EN
//     0x40+4*i PRIO  RW   [PRIO_W-1:0], i = 1..NUM_SRC

module cpu_irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [7:0]         addr,
  input  logic [31:0]        wdata,
  input  logic               wstrobe,
  input  logic               rstrobe,
  output logic [31:0]        rdata,
  output logic               mei_pending
);

  // Source IDs need 5 bits: 1..31, and 0 means "no source".
  localparam int ID_W = 5;

  // Word offsets (addr[7:2]) of the fixed registers.
  localparam logic [5:0] W_PENDING   = 6'd0;
  localparam logic [5:0] W_ENABLE    = 6'd1;
  localparam logic [5:0] W_THRESHOLD = 6'd2;
  localparam logic [5:0] W_CLAIM     = 6'd3;
  localparam logic [5:0] W_EDGE      = 6'd4;
  // PRIO[i] sits at word W_PRIO_BASE + i.
  localparam int         W_PRIO_BASE = 16;

  // Per-source state. Bit i-1 of each vector belongs to source ID i.
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [NUM_SRC];

  logic [5:0]         word;
  logic               claim_fire;
  logic               cpl_fire;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] cpl_mask;
  logic [NUM_SRC-1:0] gw_set;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] in_service_nxt;
  logic [31:0]        rd_mux;

  // The low address bits and the unused high write-data bits are ignored.
  logic               unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign word       = addr[7:2];
  assign claim_fire = rstrobe && (word == W_CLAIM);
  assign cpl_fire   = wstrobe && (word == W_CLAIM);

`ifdef IRQ_EDGE_EN
  // Edge-mode select per source, and the prior sample of src for edge detection.
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] src_q;

  // Edge-mode sources pend on a rise even while in service (one level of
  // queueing). A rise that arrives while the source is already pending is lost.
  assign gw_set = ~pending & ((edge_mode & src & ~src_q) |
                              (~edge_mode & src & ~in_service));
`else
  // Level gateway: a high source pends unless it is already pending or in service.
  assign gw_set = src & ~pending & ~in_service;
`endif

  // Arbitration: the highest priority strictly above the threshold wins.
  // Scanning from the lowest ID with a strict compare makes ties go to the lower ID.
  // Priority 0 can never beat the threshold, so such a source never interrupts.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments, so each loop
    // iteration sees the best_prio left by the one before it.
    win_id    = '0;
    best_prio = threshold;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        win_id    = ID_W'(i + 1);
      end
    end
  end

  // Decode the claim of the current winner and the complete of the written ID.
  always_comb begin
    claim_mask = '0;
    cpl_mask   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim_fire && (win_id == ID_W'(i + 1)))
        claim_mask[i] = 1'b1;
      if (cpl_fire && (wdata[ID_W-1:0] == ID_W'(i + 1)))
        cpl_mask[i] = 1'b1;
    end
  end

  // Next pending / in-service state. A claim clears pending and sets in_service.
  // A complete clears in_service. When a claim and a complete hit the same ID in
  // one cycle, the claim wins, so the source ends up in service.
  always_comb begin
    pending_nxt    = (pending | gw_set) & ~claim_mask;
    in_service_nxt = (in_service & ~cpl_mask) | claim_mask;
  end

  // Read mux. Every value is pre-edge state, so a read in the same cycle as a
  // write returns the old contents. Unmapped words read as zero.
  always_comb begin
    // NOTE: rd_mux gets a default before the case. This keeps any unlisted
    // address from inferring a latch.
    rd_mux = '0;
    case (word)
      W_PENDING:   rd_mux[NUM_SRC:1]  = pending;
      W_ENABLE:    rd_mux[NUM_SRC:1]  = enable;
      W_THRESHOLD: rd_mux[PRIO_W-1:0] = threshold;
      W_CLAIM:     rd_mux[ID_W-1:0]   = win_id;
`ifdef IRQ_EDGE_EN
      W_EDGE:      rd_mux[NUM_SRC:1]  = edge_mode;
`endif
      default:     rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_SRC; i++) begin
      if (word == 6'(W_PRIO_BASE + i + 1))
        rd_mux[PRIO_W-1:0] = prio[i];
    end
  end

  // Main state and register file. Reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      in_service  <= '0;
      enable      <= '0;
      threshold   <= '0;
      rdata       <= '0;
      mei_pending <= 1'b0;
      // NOTE: the priority array is small and must read 0 after reset, so it
      // is reset with the other registers rather than left as uninitialised RAM.
      for (int i = 0; i < NUM_SRC; i++)
        prio[i] <= '0;
    end else begin
      pending     <= pending_nxt;
      in_service  <= in_service_nxt;
      mei_pending <= (win_id != '0);
      if (rstrobe)
        rdata <= rd_mux;
      if (wstrobe) begin
        case (word)
          W_ENABLE:    enable    <= wdata[NUM_SRC:1];
          W_THRESHOLD: threshold <= wdata[PRIO_W-1:0];
          default:     ;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
          if (word == 6'(W_PRIO_BASE + i + 1))
            prio[i] <= wdata[PRIO_W-1:0];
        end
      end
    end
  end

`ifdef IRQ_EDGE_EN
  // Edge-mode register and the prior sample of src. Both reset to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_mode <= '0;
      src_q     <= '0;
    end else begin
      src_q <= src;
      if (wstrobe && (word == W_EDGE))
        edge_mode <= wdata[NUM_SRC:1];
    end
  end
`endif

endmodule
